// File: rtl/forth_pkg.sv
// Shared definitions for the Forth data stack: opcode encoding and its width.
package forth_pkg;

    localparam int OP_W = 3;

    localparam logic [OP_W-1:0] OP_NOP     = 3'd0;
    localparam logic [OP_W-1:0] OP_PUSH    = 3'd1;
    localparam logic [OP_W-1:0] OP_POP     = 3'd2;
    localparam logic [OP_W-1:0] OP_DUP     = 3'd3;
    localparam logic [OP_W-1:0] OP_SWAP    = 3'd4;
    localparam logic [OP_W-1:0] OP_OVER    = 3'd5;
    localparam logic [OP_W-1:0] OP_BINOP   = 3'd6;
    localparam logic [OP_W-1:0] OP_REPLACE = 3'd7;

endpackage

// File: rtl/forth_stack_spill.sv
// Spill register file for the Forth data stack: DEPTH-2 entries, one
// synchronous write port and one combinational read port. Addresses past the
// last entry read back as 0. Optional macro FORTH_STACK_PICK_EN adds a second
// combinational read port for random access from the top of the stack.
module forth_stack_spill #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 64,
    parameter int CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [CNT_W-1:0]  wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [CNT_W-1:0]  rd_addr,
`ifdef FORTH_STACK_PICK_EN
    input  logic [CNT_W-1:0]  pick_addr,
    output logic [DATA_W-1:0] pick_data,
`endif
    output logic [DATA_W-1:0] rd_data
);

    localparam int N = DEPTH - 2;

    logic [DATA_W-1:0] mem [N];

    // Register-file write; contents are deliberately not reset.
    always_ff @(posedge clk) begin
        for (int i = 0; i < N; i++) begin
            if (wr_en && (wr_addr == CNT_W'(i))) begin
                mem[i] <= wr_data;
            end
        end
    end

    // Combinational refill read; out-of-range addresses yield 0.
    always_comb begin
        rd_data = '0;
        for (int i = 0; i < N; i++) begin
            if (rd_addr == CNT_W'(i)) begin
                rd_data = mem[i];
            end
        end
    end

`ifdef FORTH_STACK_PICK_EN
    // Combinational pick read; out-of-range addresses yield 0.
    always_comb begin
        pick_data = '0;
        for (int i = 0; i < N; i++) begin
            if (pick_addr == CNT_W'(i)) begin
                pick_data = mem[i];
            end
        end
    end
`endif

endmodule

// File: rtl/forth_stack_mem.sv
// Forth data stack: TOS and NOS held in registers, deeper entries spilled to
// a register file. One op per clock, sticky overflow/underflow flags.
// Optional macro FORTH_STACK_PICK_EN adds i_PICK/o_PICK random read access.
module forth_stack_mem
    import forth_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 64,
    parameter int CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic              c_CLOCK,
    input  logic              i_RESETN,
    input  logic [OP_W-1:0]   i_OP,
    input  logic [DATA_W-1:0] i_DATA,
    input  logic              i_CLR_ERR,
`ifdef FORTH_STACK_PICK_EN
    input  logic [CNT_W-1:0]  i_PICK,
    output logic [DATA_W-1:0] o_PICK,
`endif
    output logic [DATA_W-1:0] o_TOS,
    output logic [DATA_W-1:0] o_NOS,
    output logic [CNT_W-1:0]  o_DEPTH,
    output logic              o_EMPTY,
    output logic              o_FULL,
    output logic              o_OVF,
    output logic              o_UNF
);

    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    logic [DATA_W-1:0] tos, nos, tos_nx, nos_nx;
    logic [CNT_W-1:0]  cnt, cnt_nx;
    logic              ovf, unf, ovf_set, unf_set;
    logic              has1, has2, room;
    logic              spill_we;
    logic [CNT_W-1:0]  spill_waddr, refill_raddr;
    logic [DATA_W-1:0] spill_rdata, refill;

    // Spill slot is depth-2 (old NOS goes just above the array top);
    // refill slot is depth-3 (current array top).
    assign spill_waddr  = cnt - CNT_W'(2);
    assign refill_raddr = cnt - CNT_W'(3);

`ifdef FORTH_STACK_PICK_EN
    logic [CNT_W-1:0]  pick_addr;
    logic [DATA_W-1:0] pick_data;

    assign pick_addr = cnt - CNT_W'(1) - i_PICK;
`endif

    forth_stack_spill #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .CNT_W  (CNT_W)
    ) u_spill (
        .clk       (c_CLOCK),
        .wr_en     (spill_we),
        .wr_addr   (spill_waddr),
        .wr_data   (nos),
        .rd_addr   (refill_raddr),
`ifdef FORTH_STACK_PICK_EN
        .pick_addr (pick_addr),
        .pick_data (pick_data),
`endif
        .rd_data   (spill_rdata)
    );

    // Decode the op: check its depth requirement, then form next TOS/NOS/depth.
    always_comb begin
        tos_nx   = tos;
        nos_nx   = nos;
        cnt_nx   = cnt;
        ovf_set  = 1'b0;
        unf_set  = 1'b0;
        spill_we = 1'b0;
        has1     = (cnt >= CNT_W'(1));
        has2     = (cnt >= CNT_W'(2));
        room     = (cnt < DEPTH_C);
        // An empty array refills as 0 so vacated slots read back clean.
        refill   = (cnt >= CNT_W'(3)) ? spill_rdata : '0;
        case (i_OP)
            OP_PUSH: begin
                if (!room) begin
                    ovf_set = 1'b1;
                end else begin
                    tos_nx   = i_DATA;
                    nos_nx   = tos;
                    cnt_nx   = cnt + CNT_W'(1);
                    spill_we = has2;
                end
            end
            OP_POP: begin
                if (!has1) begin
                    unf_set = 1'b1;
                end else begin
                    tos_nx = nos;
                    nos_nx = refill;
                    cnt_nx = cnt - CNT_W'(1);
                end
            end
            OP_DUP: begin
                if (!has1) begin
                    unf_set = 1'b1;
                end else if (!room) begin
                    ovf_set = 1'b1;
                end else begin
                    nos_nx   = tos;
                    cnt_nx   = cnt + CNT_W'(1);
                    spill_we = has2;
                end
            end
            OP_SWAP: begin
                if (!has2) begin
                    unf_set = 1'b1;
                end else begin
                    tos_nx = nos;
                    nos_nx = tos;
                end
            end
            OP_OVER: begin
                if (!has2) begin
                    unf_set = 1'b1;
                end else if (!room) begin
                    ovf_set = 1'b1;
                end else begin
                    tos_nx   = nos;
                    nos_nx   = tos;
                    cnt_nx   = cnt + CNT_W'(1);
                    spill_we = 1'b1;
                end
            end
            OP_BINOP: begin
                if (!has2) begin
                    unf_set = 1'b1;
                end else begin
                    tos_nx = i_DATA;
                    nos_nx = refill;
                    cnt_nx = cnt - CNT_W'(1);
                end
            end
            OP_REPLACE: begin
                if (!has1) begin
                    unf_set = 1'b1;
                end else begin
                    tos_nx = i_DATA;
                end
            end
            default: ;
        endcase
    end

    // Stack registers and sticky error flags; a new error beats the clear.
    always_ff @(posedge c_CLOCK) begin
        if (!i_RESETN) begin
            tos <= '0;
            nos <= '0;
            cnt <= '0;
            ovf <= 1'b0;
            unf <= 1'b0;
        end else begin
            tos <= tos_nx;
            nos <= nos_nx;
            cnt <= cnt_nx;
            ovf <= ovf_set | (ovf & ~i_CLR_ERR);
            unf <= unf_set | (unf & ~i_CLR_ERR);
        end
    end

`ifdef FORTH_STACK_PICK_EN
    // Random read from the top: 0 = TOS, 1 = NOS, deeper from the array.
    always_comb begin
        if (i_PICK >= cnt) begin
            o_PICK = '0;
        end else if (i_PICK == CNT_W'(0)) begin
            o_PICK = tos;
        end else if (i_PICK == CNT_W'(1)) begin
            o_PICK = nos;
        end else begin
            o_PICK = pick_data;
        end
    end
`endif

    assign o_TOS   = tos;
    assign o_NOS   = nos;
    assign o_DEPTH = cnt;
    assign o_EMPTY = (cnt == '0);
    assign o_FULL  = (cnt == DEPTH_C);
    assign o_OVF   = ovf;
    assign o_UNF   = unf;

endmodule

// File: tb/tb_forth_stack_mem.sv
// Directed bench for forth_stack_mem with DEPTH=8: a vector table of ops and
// hand-computed results, plus fill/drain and pick sequences.
module tb_forth_stack_mem;
    import forth_pkg::*;

    localparam int DW = 16;
    localparam int DP = 8;
    localparam int CW = $clog2(DP + 1);

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic [2:0]    op = OP_NOP;
    logic [DW-1:0] data = '0;
    logic          clr = 1'b0;
    logic [DW-1:0] tos, nos;
    logic [CW-1:0] depth;
    logic          empty, full, ovf, unf;
`ifdef FORTH_STACK_PICK_EN
    logic [CW-1:0] pick = '0;
    logic [DW-1:0] pick_out;
`endif

    int checks = 0;
    int errors = 0;

    forth_stack_mem #(.DATA_W(DW), .DEPTH(DP)) dut (
        .c_CLOCK   (clk),
        .i_RESETN  (rstn),
        .i_OP      (op),
        .i_DATA    (data),
        .i_CLR_ERR (clr),
`ifdef FORTH_STACK_PICK_EN
        .i_PICK    (pick),
        .o_PICK    (pick_out),
`endif
        .o_TOS     (tos),
        .o_NOS     (nos),
        .o_DEPTH   (depth),
        .o_EMPTY   (empty),
        .o_FULL    (full),
        .o_OVF     (ovf),
        .o_UNF     (unf)
    );

    always #5 clk = ~clk;

    typedef struct {
        string         name;
        logic [2:0]    op;
        logic [DW-1:0] data;
        logic          rstn;
        logic          clr;
        logic [DW-1:0] tos;
        logic [DW-1:0] nos;
        logic [CW-1:0] depth;
        logic          ovf;
        logic          unf;
    } vec_t;

    vec_t vq[$];

    task automatic add(input string name, input logic [2:0] o, input logic [DW-1:0] d,
                       input logic r, input logic c, input logic [DW-1:0] et,
                       input logic [DW-1:0] en, input int ed, input logic eo, input logic eu);
        vec_t v;
        v.name = name; v.op = o; v.data = d; v.rstn = r; v.clr = c;
        v.tos = et; v.nos = en; v.depth = CW'(ed); v.ovf = eo; v.unf = eu;
        vq.push_back(v);
    endtask

    task automatic apply(input logic [2:0] o, input logic [DW-1:0] d, input logic r, input logic c);
        op = o; data = d; rstn = r; clr = c;
        @(posedge clk);
        #1;
        op = OP_NOP; data = '0; rstn = 1'b1; clr = 1'b0;
    endtask

    // Compares every output against expectations; empty/full derive from depth.
    task automatic check(input string name, input logic [DW-1:0] et, input logic [DW-1:0] en,
                         input logic [CW-1:0] ed, input logic eo, input logic eu);
        logic ee, ef;
        ee = (ed == 0);
        ef = (ed == CW'(DP));
        checks++;
        if (tos !== et || nos !== en || depth !== ed || ovf !== eo || unf !== eu ||
            empty !== ee || full !== ef) begin
            errors++;
            $display("FAIL %s: got tos=%h nos=%h depth=%0d ovf=%b unf=%b empty=%b full=%b, expected tos=%h nos=%h depth=%0d ovf=%b unf=%b empty=%b full=%b",
                     name, tos, nos, depth, ovf, unf, empty, full, et, en, ed, eo, eu, ee, ef);
        end
    endtask

    initial begin
        // name, op, data, rstn, clr, tos, nos, depth, ovf, unf
        add("reset",        OP_NOP,     16'h0000, 0, 0, 16'h0000, 16'h0000, 0, 0, 0);
        add("push11",       OP_PUSH,    16'h0011, 1, 0, 16'h0011, 16'h0000, 1, 0, 0);
        add("push22",       OP_PUSH,    16'h0022, 1, 0, 16'h0022, 16'h0011, 2, 0, 0);
        add("push33",       OP_PUSH,    16'h0033, 1, 0, 16'h0033, 16'h0022, 3, 0, 0);
        add("pop_a",        OP_POP,     16'h0000, 1, 0, 16'h0022, 16'h0011, 2, 0, 0);
        add("pop_b",        OP_POP,     16'h0000, 1, 0, 16'h0011, 16'h0000, 1, 0, 0);
        add("reset2",       OP_NOP,     16'h0000, 0, 0, 16'h0000, 16'h0000, 0, 0, 0);
        add("pop_empty",    OP_POP,     16'h0000, 1, 0, 16'h0000, 16'h0000, 0, 0, 1);
        add("clr_alone",    OP_NOP,     16'h0000, 1, 1, 16'h0000, 16'h0000, 0, 0, 0);
        add("clr_with_pop", OP_POP,     16'h0000, 1, 1, 16'h0000, 16'h0000, 0, 0, 1);
        add("reset3",       OP_NOP,     16'h0000, 0, 0, 16'h0000, 16'h0000, 0, 0, 0);
        add("push5",        OP_PUSH,    16'h0005, 1, 0, 16'h0005, 16'h0000, 1, 0, 0);
        add("push7",        OP_PUSH,    16'h0007, 1, 0, 16'h0007, 16'h0005, 2, 0, 0);
        add("swap",         OP_SWAP,    16'h0000, 1, 0, 16'h0005, 16'h0007, 2, 0, 0);
        add("over",         OP_OVER,    16'h0000, 1, 0, 16'h0007, 16'h0005, 3, 0, 0);
        add("binop",        OP_BINOP,   16'h000C, 1, 0, 16'h000C, 16'h0007, 2, 0, 0);
        add("replace",      OP_REPLACE, 16'h0099, 1, 0, 16'h0099, 16'h0007, 2, 0, 0);
        add("dup",          OP_DUP,     16'h0000, 1, 0, 16'h0099, 16'h0099, 3, 0, 0);
        add("binop2",       OP_BINOP,   16'h0044, 1, 0, 16'h0044, 16'h0007, 2, 0, 0);
        add("pop_c",        OP_POP,     16'h0000, 1, 0, 16'h0007, 16'h0000, 1, 0, 0);
        add("swap_d1",      OP_SWAP,    16'h0000, 1, 0, 16'h0007, 16'h0000, 1, 0, 1);
        add("clr_b",        OP_NOP,     16'h0000, 1, 1, 16'h0007, 16'h0000, 1, 0, 0);
        add("binop_d1",     OP_BINOP,   16'h0055, 1, 0, 16'h0007, 16'h0000, 1, 0, 1);
        add("clr_c",        OP_NOP,     16'h0000, 1, 1, 16'h0007, 16'h0000, 1, 0, 0);
        add("over_d1",      OP_OVER,    16'h0000, 1, 0, 16'h0007, 16'h0000, 1, 0, 1);
        add("clr_d",        OP_NOP,     16'h0000, 1, 1, 16'h0007, 16'h0000, 1, 0, 0);
        add("dup_d1",       OP_DUP,     16'h0000, 1, 0, 16'h0007, 16'h0007, 2, 0, 0);
        add("pop_d",        OP_POP,     16'h0000, 1, 0, 16'h0007, 16'h0000, 1, 0, 0);
        add("reset4",       OP_NOP,     16'h0000, 0, 0, 16'h0000, 16'h0000, 0, 0, 0);
        add("pushAAAA",     OP_PUSH,    16'hAAAA, 1, 0, 16'hAAAA, 16'h0000, 1, 0, 0);
        add("rst_over_push",OP_PUSH,    16'h1234, 0, 0, 16'h0000, 16'h0000, 0, 0, 0);
        add("push1234",     OP_PUSH,    16'h1234, 1, 0, 16'h1234, 16'h0000, 1, 0, 0);
        add("pop_e",        OP_POP,     16'h0000, 1, 0, 16'h0000, 16'h0000, 0, 0, 0);
        add("replace_d0",   OP_REPLACE, 16'h0055, 1, 0, 16'h0000, 16'h0000, 0, 0, 1);
        add("dup_d0",       OP_DUP,     16'h0000, 1, 1, 16'h0000, 16'h0000, 0, 0, 1);
        add("reset5",       OP_NOP,     16'h0000, 0, 0, 16'h0000, 16'h0000, 0, 0, 0);

        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < vq.size(); i++) begin
            apply(vq[i].op, vq[i].data, vq[i].rstn, vq[i].clr);
            check(vq[i].name, vq[i].tos, vq[i].nos, vq[i].depth, vq[i].ovf, vq[i].unf);
        end

        // Fill to capacity: FULL at depth DEPTH with no error.
        for (int i = 1; i <= DP; i++) begin
            apply(OP_PUSH, DW'(i), 1'b1, 1'b0);
            check("fill", DW'(i), DW'(i - 1), CW'(i), 1'b0, 1'b0);
        end
        apply(OP_PUSH, 16'd9, 1'b1, 1'b0);
        check("push_full", 16'd8, 16'd7, CW'(DP), 1'b1, 1'b0);
        apply(OP_NOP, 16'd0, 1'b1, 1'b1);
        check("clr_ovf", 16'd8, 16'd7, CW'(DP), 1'b0, 1'b0);
        apply(OP_DUP, 16'd0, 1'b1, 1'b1);
        check("dup_full_setwins", 16'd8, 16'd7, CW'(DP), 1'b1, 1'b0);
        apply(OP_NOP, 16'd0, 1'b1, 1'b1);
        apply(OP_OVER, 16'd0, 1'b1, 1'b0);
        check("over_full", 16'd8, 16'd7, CW'(DP), 1'b1, 1'b0);

`ifdef FORTH_STACK_PICK_EN
        apply(OP_NOP, 16'd0, 1'b1, 1'b1);
        for (int k = 0; k < DP; k++) begin
            pick = CW'(k);
            #1;
            checks++;
            if (pick_out !== DW'(DP - k)) begin
                errors++;
                $display("FAIL pick_full k=%0d: got %h expected %h", k, pick_out, DW'(DP - k));
            end
        end
`endif

        // Drain: each POP refills NOS from the spill array.
        for (int j = 1; j <= DP; j++) begin
            apply(OP_POP, 16'd0, 1'b1, 1'b1);
            check("drain", DW'(DP - j), (j < DP - 1) ? DW'(DP - 1 - j) : DW'(0),
                  CW'(DP - j), 1'b0, 1'b0);
        end

`ifdef FORTH_STACK_PICK_EN
        for (int i = 1; i <= 4; i++) apply(OP_PUSH, DW'(i), 1'b1, 1'b0);
        pick = CW'(0); #1;
        checks++;
        if (pick_out !== 16'd4) begin errors++; $display("FAIL pick0: got %h expected 0004", pick_out); end
        pick = CW'(3); #1;
        checks++;
        if (pick_out !== 16'd1) begin errors++; $display("FAIL pick3: got %h expected 0001", pick_out); end
        pick = CW'(4); #1;
        checks++;
        if (pick_out !== 16'd0) begin errors++; $display("FAIL pick4: got %h expected 0000", pick_out); end
        apply(OP_NOP, 16'd0, 1'b1, 1'b0);
        check("pick_no_unf", 16'd4, 16'd3, CW'(4), 1'b0, 1'b0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/forth_stack_mem.md
Name: forth_stack_mem

Overview:
- Parametrised single-clock data stack for the Forth core. Successor to the fixed 16x64 stack memory.
- Keeps TOS and NOS in registers, so both are valid every cycle; the remaining entries live in a register-file spill array.
- Executes one stack op per clock: push, pop, dup, swap, over, binop-writeback and replace.
- Tracks depth, flags full/empty, and latches sticky overflow/underflow errors.

Parameters:
- DATA_W, 16, word width in bits.
- DEPTH, 64, maximum number of stack entries, including TOS and NOS; must be at least 4.
- CNT_W, $clog2(DEPTH+1), width of the depth counter.

Ports:
- c_CLOCK  in  1  system clock; all state changes on the rising edge.
- i_RESETN  in  1  synchronous active-low reset.
- i_OP  in  3  stack operation code; see Behaviour.
- i_DATA  in  DATA_W  operand for PUSH, BINOP and REPLACE.
- i_CLR_ERR  in  1  clears the sticky error flags.
- o_TOS  out  DATA_W  top of stack, registered.
- o_NOS  out  DATA_W  second element, registered.
- o_DEPTH  out  CNT_W  current number of entries.
- o_EMPTY  out  1  high when depth is 0.
- o_FULL  out  1  high when depth equals DEPTH.
- o_OVF  out  1  sticky overflow flag.
- o_UNF  out  1  sticky underflow flag.

Behaviour:
- Clocking and reset:
  - Single clock domain. Reset is synchronous and active-low: i_RESETN is sampled at the c_CLOCK rising edge.
  - Reset sets depth to 0, o_TOS and o_NOS to 0, o_OVF and o_UNF to 0.
  - The spill array is not cleared by reset.
  - Reset overrides any i_OP issued in the same cycle.
- Opcodes (i_OP) and their results:
  - 0 NOP: no change.
  - 1 PUSH: TOS <= i_DATA, NOS <= old TOS, old NOS spills to the array. Depth +1. Requires depth < DEPTH.
  - 2 POP: TOS <= NOS, NOS <= top of array. Depth -1. Requires depth >= 1.
  - 3 DUP: NOS <= TOS, old NOS spills. Depth +1. Requires 1 <= depth < DEPTH.
  - 4 SWAP: TOS and NOS exchange. Requires depth >= 2.
  - 5 OVER: TOS <= NOS, NOS <= old TOS, old NOS spills. Depth +1. Requires 2 <= depth < DEPTH.
  - 6 BINOP: consumes TOS and NOS, then pushes i_DATA as the result. TOS <= i_DATA, NOS <= top of array. Depth -1. Requires depth >= 2.
  - 7 REPLACE: TOS <= i_DATA; depth unchanged. Requires depth >= 1.
- Latency:
  - Registered outputs reflect the op from the same edge, i.e. they are valid one cycle after i_OP is presented.
  - Back-to-back ops every cycle are supported with no bubbles.
- Spill array:
  - Holds entries 3..DEPTH at indices 0..DEPTH-3.
  - Spill write pointer = depth-2 before the op; refill read pointer = depth-3 before the op.
  - Read is combinational, so the array is built from registers, not inferred block RAM.
- Empty slots:
  - When depth < 2, o_NOS = 0; when depth = 0, o_TOS = 0.
  - A refill from an empty array (depth <= 2 before the op) loads 0.
- Errors:
  - Any op whose requirement fails is suppressed entirely: no state change except the error flag.
  - Depth too high sets o_OVF; depth too low sets o_UNF.
  - Error flags are sticky until i_CLR_ERR or reset.
  - If i_CLR_ERR and a new error occur in the same cycle, the flag is set (set wins).
- Flags: o_EMPTY and o_FULL are decoded combinationally from the registered depth.
- Boundaries:
  - PUSH at depth DEPTH-1 reaches FULL with no error.
  - POP at depth 1 reaches EMPTY and o_TOS = 0.
  - SWAP at depth 1 sets o_UNF; TOS and depth are untouched.

Optional Feature:
- Macro: FORTH_STACK_PICK_EN.
- When defined:
  - Adds ports i_PICK (in, CNT_W) and o_PICK (out, DATA_W).
  - o_PICK is a combinational read of entry i_PICK counted from the top: 0 = TOS, 1 = NOS, k>=2 = array[depth-1-k].
  - If i_PICK >= depth, o_PICK = 0 and o_UNF is not set.
- When undefined: neither port exists and no extra logic is built.

Decomposition:
- Package forth_pkg holds:
  - the opcode localparams: OP_NOP, OP_PUSH, OP_POP, OP_DUP, OP_SWAP, OP_OVER, OP_BINOP, OP_REPLACE;
  - the opcode width constant, 3.
- One sub-module, forth_stack_spill: DEPTH-2 entry register file with one synchronous write port and one combinational read port. Under FORTH_STACK_PICK_EN it adds a second combinational read port.

Test Plan:
- PUSH 0x0011, 0x0022, 0x0033 -> o_TOS=0x0033, o_NOS=0x0022, o_DEPTH=3. Then POP, POP -> o_TOS=0x0011, o_NOS=0, o_DEPTH=1.
- Reset, then POP -> o_UNF=1, o_DEPTH=0, o_TOS=0. Then i_CLR_ERR alone -> o_UNF=0. Then i_CLR_ERR with POP -> o_UNF=1.
- DEPTH=8: PUSH 1..8 -> o_FULL=1, no error. PUSH 9 -> o_OVF=1, o_TOS=8. Then POP x8 -> TOS sequence 7..1, then EMPTY.
- Stack [5,7], TOS=7: SWAP -> TOS=5, NOS=7. OVER -> TOS=7, NOS=5, depth 3. BINOP with i_DATA=0x000C -> TOS=0x000C, NOS=7, depth 2.
- Stack [0xAAAA], then i_RESETN=0 together with PUSH 0x1234 -> depth 0, o_TOS=0. The first op after reset executes normally.
- FORTH_STACK_PICK_EN: stack [1,2,3,4], TOS=4 -> i_PICK=0 gives 4, i_PICK=3 gives 1, i_PICK=4 gives 0 with o_UNF unchanged.
